multiplier: RTL and testbench

- Sequential unsigned integer multiplier using radix-2 shift-and-add, one partial product per clock.
- Sits as a shared arithmetic resource behind a simple Start/Ready handshake.
- Trades latency (DATA_WIDTH cycles) for area versus a combinational array multiplier.

---
 rtl/multiplier_pkg.sv | 21 ++
 rtl/multiplier.sv | 84 ++++++++
 tb/tb_multiplier.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared types and sizing helpers for the shift-and-add multiplier
package multiplier_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Bits needed to hold the values 0..n (clog2(n+1)); operand widths top out at 32.
   function automatic int count_width(input int n);
      int w;
      w = 1;
      for (int i = 0; i < 8; i++) begin
         if ((1 << i) < (n + 1)) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/multiplier.sv
// rtl/multiplier.sv - radix-2 sequential unsigned multiplier, one partial product per clock
module multiplier
   import multiplier_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                      Clk,
   input  logic                      ResetN,
   input  logic [DATA_WIDTH-1:0]     InputA,
   input  logic [DATA_WIDTH-1:0]     InputB,
   input  logic                      Start,
   output logic [2*DATA_WIDTH-1:0]   Product,
   output logic                      Ready
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int CW = count_width(DATA_WIDTH);

   state_t                state, state_n;
   logic [PW-1:0]         acc, acc_n;
   logic [PW-1:0]         mcand, mcand_n;
   logic [DATA_WIDTH-1:0] mplier, mplier_n;
   logic [CW-1:0]         count, count_n;
   logic [PW-1:0]         product_n;
   logic [PW-1:0]         sum;

   // Accumulator plus this cycle's partial product; also the final result on the last step.
   assign sum = acc + (mplier[0] ? mcand : {PW{1'b0}});

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state   <= IDLE;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         count   <= '0;
         Product <= '0;
      end else begin
         state   <= state_n;
         acc     <= acc_n;
         mcand   <= mcand_n;
         mplier  <= mplier_n;
         count   <= count_n;
         Product <= product_n;
      end
   end

   always_comb begin
      state_n   = state;
      acc_n     = acc;
      mcand_n   = mcand;
      mplier_n  = mplier;
      count_n   = count;
      product_n = Product;
      case (state)
         IDLE: begin
            if (Start) begin
               state_n  = BUSY;
               acc_n    = '0;
               mcand_n  = {{DATA_WIDTH{1'b0}}, InputA};
               mplier_n = InputB;
               count_n  = CW'(DATA_WIDTH);
            end
         end
         BUSY: begin
            acc_n    = sum;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            count_n  = count - CW'(1);
            // Always run the full width: no early exit when the multiplier runs out of ones.
            if (count == CW'(1)) begin
               state_n   = IDLE;
               product_n = sum;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign Ready = (state == IDLE);

endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - directed self-checking bench for the sequential multiplier
module tb_multiplier;

   logic        clk;
   logic        rst_n;
   logic [15:0] a16, b16;
   logic        start16;
   logic [31:0] product16;
   logic        ready16;
   logic [7:0]  a8, b8;
   logic        start8;
   logic [15:0] product8;
   logic        ready8;

   int tests;
   int fails;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
   } vec_t;

   vec_t vecs[8];

   multiplier #(.DATA_WIDTH(16)) dut16 (
      .Clk(clk), .ResetN(rst_n), .InputA(a16), .InputB(b16),
      .Start(start16), .Product(product16), .Ready(ready16)
   );

   multiplier #(.DATA_WIDTH(8)) dut8 (
      .Clk(clk), .ResetN(rst_n), .InputA(a8), .InputB(b8),
      .Start(start8), .Product(product8), .Ready(ready8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One 16-bit operation: start pulse, busy-length count, mid-op hold check, result check.
   task automatic run16(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input logic [31:0] prev, input string tag);
      int cyc;
      @(negedge clk);
      a16 = a; b16 = b; start16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, " busy"}, 64'(ready16), 64'(0));
      start16 = 1'b0;
      cyc = 0;
      while (!ready16 && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (cyc == 8) check({tag, " hold"}, 64'(product16), 64'(prev));
      end
      check({tag, " latency"}, 64'(cyc), 64'(16));
      check({tag, " product"}, 64'(product16), 64'(exp));
   endtask

   initial begin
      int cyc;
      logic [31:0] prev;
      tests = 0;
      fails = 0;

      vecs[0] = '{16'd4,      16'd5,      32'd20};
      vecs[1] = '{16'hFFFF,   16'hFFFF,   32'hFFFE0001};
      vecs[2] = '{16'd0,      16'h1234,   32'd0};
      vecs[3] = '{16'h1234,   16'd0,      32'd0};
      vecs[4] = '{16'd1,      16'hFFFF,   32'h0000FFFF};
      vecs[5] = '{16'h8000,   16'd2,      32'h00010000};
      vecs[6] = '{16'h00FF,   16'h0101,   32'h0000FFFF};
      vecs[7] = '{16'd4,      16'd5,      32'd20};

      rst_n = 1'b0;
      a16 = '0; b16 = '0; start16 = 1'b0;
      a8 = '0; b8 = '0; start8 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset ready", 64'(ready16), 64'(1));
      check("reset product", 64'(product16), 64'(0));
      check("reset ready w8", 64'(ready8), 64'(1));

      prev = 32'd0;
      for (int i = 0; i < 8; i++) begin
         run16(vecs[i].a, vecs[i].b, vecs[i].p, prev, $sformatf("vec%0d", i));
         prev = vecs[i].p;
      end

      // Operand isolation and Start ignored while busy.
      @(negedge clk);
      a16 = 16'd3; b16 = 16'd7; start16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom);
      cyc = 0;
      while (!ready16 && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (cyc == 4) start16 = 1'b1;
         if (cyc == 5) begin
            start16 = 1'b0;
            a16 = 16'($urandom); b16 = 16'($urandom);
         end
         if (cyc == 10) check("iso hold", 64'(product16), 64'(20));
      end
      check("iso latency", 64'(cyc), 64'(16));
      check("iso product", 64'(product16), 64'(21));
      repeat (3) @(negedge clk);
      check("iso no relaunch", 64'(ready16), 64'(1));
      check("iso idle hold", 64'(product16), 64'(21));

      // Start held high: back-to-back operations with one Ready-high cycle between them.
      @(negedge clk);
      a16 = 16'd2; b16 = 16'd3; start16 = 1'b1;
      for (int op = 0; op < 2; op++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("b2b%0d busy", op), 64'(ready16), 64'(0));
         cyc = 0;
         while (!ready16 && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
         end
         check($sformatf("b2b%0d latency", op), 64'(cyc), 64'(16));
         check($sformatf("b2b%0d product", op), 64'(product16), 64'(6));
      end
      start16 = 1'b0;
      @(negedge clk);
      check("b2b idle after drop", 64'(ready16), 64'(1));

      // Asynchronous reset mid-operation.
      @(negedge clk);
      a16 = 16'd100; b16 = 16'd100; start16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start16 = 1'b0;
      repeat (7) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("midrst busy", 64'(ready16), 64'(0));
      #2 rst_n = 1'b0;
      #1;
      check("midrst ready", 64'(ready16), 64'(1));
      check("midrst product", 64'(product16), 64'(0));
      #1 rst_n = 1'b1;
      run16(16'd9, 16'd9, 32'd81, 32'd0, "after rst");

      // Narrow instance.
      @(negedge clk);
      a8 = 8'd200; b8 = 8'd250; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("w8 busy", 64'(ready8), 64'(0));
      start8 = 1'b0;
      cyc = 0;
      while (!ready8 && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      check("w8 latency", 64'(cyc), 64'(8));
      check("w8 product", 64'(product8), 64'(16'd50000));

      @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      cyc = 0;
      while (!ready8 && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      check("w8 max latency", 64'(cyc), 64'(8));
      check("w8 max product", 64'(product8), 64'(16'hFE01));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
